// File: rtl/poci_regbank.sv
// POCI readout register bank: NUM_WR host-writable words plus read-only status
// words, streamed out through a framed parallel-to-serial shifter.
module poci_regbank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_REGS  = 59,
  parameter int NUM_WR    = 3,
  parameter int LSB_FIRST = 1
) (
  input  logic                                sclk,
  input  logic                                rstn,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic                                wr_en,
  input  logic [DATA_W-1:0]                   write_data,
  input  logic                                start,
  input  logic [(NUM_REGS-NUM_WR)*DATA_W-1:0] ro_regs,
  output logic [NUM_WR*DATA_W-1:0]            wr_regs,
  output logic                                serial_out,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                addr_err
);
  localparam int NUM_RO = NUM_REGS - NUM_WR;
  localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                        state_q, state_d;
  logic [DATA_W-1:0]             sreg_q, sreg_d;
  logic [DATA_W-1:0]             cnt_q, cnt_d;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_q, wr_d;
  logic                          serial_out_q, serial_out_d;
  logic                          busy_q, busy_d;
  logic                          frame_done_q, frame_done_d;
  logic                          addr_err_q, addr_err_d;

  logic [NUM_RO-1:0][DATA_W-1:0] ro_words;
  logic [DATA_W-1:0]             rd_word;
  logic                          rd_valid;
  logic                          wr_hit;
  logic                          load;

  assign ro_words = ro_regs;

  // Read selection: writable words first, then read-only words; unmapped reads zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    rd_word  = '0;
    rd_valid = 1'b0;
    wr_hit   = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (addr == ADDR_W'(i + 1)) begin
        rd_word  = wr_q[i];
        rd_valid = 1'b1;
        wr_hit   = 1'b1;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (addr == ADDR_W'(NUM_WR + 1 + j)) begin
        rd_word  = ro_words[j];
        rd_valid = 1'b1;
      end
    end
  end

  // A new frame is accepted from IDLE or on the last bit of the current frame.
  assign load = start && ((state_q == IDLE) || (cnt_q == '0));

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    serial_out_d = serial_out_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    addr_err_d   = 1'b0;

    if (wr_en) begin
      if (wr_hit) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (addr == ADDR_W'(i + 1)) wr_d[i] = write_data;
        end
      end else begin
        addr_err_d = 1'b1;
      end
    end

    if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        if (LSB_FIRST != 0) begin
          serial_out_d = sreg_q[0];
          sreg_d       = sreg_q >> 1;
        end else begin
          serial_out_d = sreg_q[DATA_W-1];
          sreg_d       = sreg_q << 1;
        end
        cnt_d = cnt_q - 1'b1;
      end else begin
        serial_out_d = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
    end

    // The snapshot reads the pre-write value, so a same-edge write never leaks into the frame.
    if (load) begin
      if (LSB_FIRST != 0) begin
        serial_out_d = rd_word[0];
        sreg_d       = rd_word >> 1;
      end else begin
        serial_out_d = rd_word[DATA_W-1];
        sreg_d       = rd_word << 1;
      end
      cnt_d   = CNT_LAST;
      busy_d  = 1'b1;
      state_d = SHIFT;
      if (!rd_valid) addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      // NOTE: the writable words are reset too, since the host expects them to read zero after reset.
      wr_q         <= '0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign wr_regs    = wr_q;
  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_poci_regbank.sv
// Bench for poci_regbank: three instances (LSB-first, MSB-first, 16-bit) checked
// every cycle against a bit-queue style reference model, plus literal expectations.
module tb_poci_regbank;
  logic sclk = 1'b0;
  logic rstn;
  always #5 sclk = ~sclk;

  logic [7:0]   a_addr, a_wdata;
  logic         a_wr_en, a_start;
  logic [447:0] a_ro;
  logic [7:0]   b_addr;
  logic [15:0]  b_wdata;
  logic         b_wr_en, b_start;
  logic [95:0]  b_ro;

  logic [23:0] wr_lsb, wr_msb;
  logic [31:0] wr_w16;
  logic        o_ser[3], o_busy[3], o_done[3], o_err[3];

  poci_regbank #(.LSB_FIRST(1)) u_lsb (
    .sclk(sclk), .rstn(rstn), .addr(a_addr), .wr_en(a_wr_en), .write_data(a_wdata),
    .start(a_start), .ro_regs(a_ro), .wr_regs(wr_lsb), .serial_out(o_ser[0]),
    .busy(o_busy[0]), .frame_done(o_done[0]), .addr_err(o_err[0]));

  poci_regbank #(.LSB_FIRST(0)) u_msb (
    .sclk(sclk), .rstn(rstn), .addr(a_addr), .wr_en(a_wr_en), .write_data(a_wdata),
    .start(a_start), .ro_regs(a_ro), .wr_regs(wr_msb), .serial_out(o_ser[1]),
    .busy(o_busy[1]), .frame_done(o_done[1]), .addr_err(o_err[1]));

  poci_regbank #(.DATA_W(16), .NUM_REGS(8), .NUM_WR(2), .LSB_FIRST(1)) u_w16 (
    .sclk(sclk), .rstn(rstn), .addr(b_addr), .wr_en(b_wr_en), .write_data(b_wdata),
    .start(b_start), .ro_regs(b_ro), .wr_regs(wr_w16), .serial_out(o_ser[2]),
    .busy(o_busy[2]), .frame_done(o_done[2]), .addr_err(o_err[2]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a word plus a count of bits still to be shown.
  logic [15:0] mwr[3][4];
  logic [15:0] fword[3];
  int          left[3];
  bit          e_done[3], e_err[3];

  function automatic int pw(input int k);  return (k == 2) ? 16 : 8;  endfunction
  function automatic int pnr(input int k); return (k == 2) ? 8 : 59;  endfunction
  function automatic int pnw(input int k); return (k == 2) ? 2 : 3;   endfunction
  function automatic bit plsb(input int k); return k != 1;            endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 3; k++) begin
      left[k] = 0; fword[k] = '0; e_done[k] = 1'b0; e_err[k] = 1'b0;
      for (int a = 0; a < 4; a++) mwr[k][a] = '0;
    end
  endtask

  task automatic mdl_step(input int k);
    int a; bit we, st, valid; logic [15:0] wd, rd;
    if (k == 2) begin
      a = int'(b_addr); we = b_wr_en; st = b_start; wd = b_wdata;
    end else begin
      a = int'(a_addr); we = a_wr_en; st = a_start; wd = {8'h00, a_wdata};
    end
    valid = (a >= 1) && (a <= pnr(k));
    rd = '0;
    if (a >= 1 && a <= pnw(k)) rd = mwr[k][a];
    else if (valid && k == 2) rd = b_ro[(a - pnw(k) - 1) * 16 +: 16];
    else if (valid) rd = {8'h00, a_ro[(a - pnw(k) - 1) * 8 +: 8]};
    e_done[k] = 1'b0;
    e_err[k]  = 1'b0;
    if (left[k] > 1) left[k]--;
    else begin
      if (left[k] == 1) begin left[k] = 0; e_done[k] = 1'b1; end
      if (st) begin
        fword[k] = rd; left[k] = pw(k);
        if (!valid) e_err[k] = 1'b1;
      end
    end
    if (we) begin
      if (a >= 1 && a <= pnw(k)) mwr[k][a] = wd;
      else e_err[k] = 1'b1;
    end
  endtask

  always @(posedge sclk or negedge rstn) begin
    if (!rstn) mdl_clear();
    else for (int k = 0; k < 3; k++) mdl_step(k);
  end

  function automatic logic exp_ser(input int k);
    if (left[k] == 0) return 1'b0;
    return plsb(k) ? fword[k][pw(k) - left[k]] : fword[k][left[k] - 1];
  endfunction

  function automatic logic [63:0] exp_wr(input int k);
    logic [63:0] v = '0;
    for (int a = 1; a <= pnw(k); a++) v = v | (64'(mwr[k][a]) << ((a - 1) * pw(k)));
    return v;
  endfunction

  function automatic logic [63:0] dut_wr(input int k);
    if (k == 0) return 64'(wr_lsb);
    if (k == 1) return 64'(wr_msb);
    return 64'(wr_w16);
  endfunction

  always @(posedge sclk) begin
    #1;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("serial_out[%0d]", k), 64'(o_ser[k]), 64'(exp_ser(k)));
        check($sformatf("busy[%0d]", k), 64'(o_busy[k]), 64'(left[k] > 0));
        check($sformatf("frame_done[%0d]", k), 64'(o_done[k]), 64'(e_done[k]));
        check($sformatf("addr_err[%0d]", k), 64'(o_err[k]), 64'(e_err[k]));
        check($sformatf("wr_regs[%0d]", k), dut_wr(k), exp_wr(k));
      end
    end
  end

  task automatic tick(); @(negedge sclk); endtask

  task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
    a_addr = ad; a_wdata = d; a_wr_en = 1'b1; tick(); a_wr_en = 1'b0;
  endtask

  // Samples DATA_W=8 bits of instance k starting at the current negedge.
  task automatic a_capture(input int k, input bit poke, output logic [7:0] cap, output int busy_lo);
    busy_lo = 0;
    for (int i = 0; i < 8; i++) begin
      cap[i] = o_ser[k];
      if (!o_busy[k]) busy_lo++;
      if (poke && i == 3) a_ro[447:440] = 8'hFF;
      tick();
    end
  endtask

  task automatic a_frame(input string nm, input int k, input logic [7:0] ad,
                         input logic [7:0] exp_bits, input logic exp_err, input bit poke);
    logic [7:0] cap; int busy_lo;
    a_addr = ad; a_start = 1'b1; tick(); a_start = 1'b0;
    check({nm, "_err"}, 64'(o_err[k]), 64'(exp_err));
    a_capture(k, poke, cap, busy_lo);
    check({nm, "_bits"}, 64'(cap), 64'(exp_bits));
    check({nm, "_busy_gap"}, 64'(busy_lo), 64'd0);
    check({nm, "_done"}, 64'(o_done[k]), 64'd1);
    check({nm, "_busy_end"}, 64'(o_busy[k]), 64'd0);
  endtask

  initial begin
    logic [15:0] cap16; int ndone, nbusy_lo;
    rstn = 1'b0;
    a_addr = '0; a_wdata = '0; a_wr_en = 1'b0; a_start = 1'b0; a_ro = '0;
    b_addr = '0; b_wdata = '0; b_wr_en = 1'b0; b_start = 1'b0; b_ro = '0;
    repeat (3) tick();
    chk_on = 1'b1;
    check("rst_wr_lsb", 64'(wr_lsb), 64'h0);
    check("rst_busy", 64'(o_busy[0]), 64'h0);
    check("rst_serial", 64'(o_ser[0]), 64'h0);
    rstn = 1'b1;
    tick();

    a_write(8'd2, 8'hA5);
    check("wr_a5", 64'(wr_lsb), 64'h00A500);
    check("wr_a5_err", 64'(o_err[0]), 64'h0);
    a_frame("lsb_a5", 0, 8'd2, 8'hA5, 1'b0, 1'b0);

    a_ro[447:440] = 8'h3C;
    a_frame("msb_3c", 1, 8'd59, 8'h3C, 1'b0, 1'b1);

    a_frame("addr0", 0, 8'd0, 8'h00, 1'b1, 1'b0);
    a_frame("addr60", 0, 8'd60, 8'h00, 1'b1, 1'b0);

    a_write(8'd10, 8'h55);
    check("wr_ro_err", 64'(o_err[0]), 64'h1);
    check("wr_ro_keep", 64'(wr_lsb), 64'h00A500);

    // Back-to-back: all-ones frame chained into an all-zeros read-only frame.
    a_write(8'd1, 8'hFF);
    a_ro[7:0] = 8'h00;
    a_addr = 8'd1; a_start = 1'b1; tick(); a_start = 1'b0;
    cap16 = '0; ndone = 0; nbusy_lo = 0;
    for (int i = 0; i < 16; i++) begin
      cap16[i] = o_ser[0];
      if (!o_busy[0]) nbusy_lo++;
      if (o_done[0]) ndone++;
      if (i == 2) begin a_addr = 8'd2; a_start = 1'b1; end
      else if (i == 7) begin a_addr = 8'd4; a_start = 1'b1; end
      else a_start = 1'b0;
      tick();
    end
    if (o_done[0]) ndone++;
    check("b2b_bits", 64'(cap16), 64'h00FF);
    check("b2b_busy_gap", 64'(nbusy_lo), 64'd0);
    check("b2b_done_cnt", 64'(ndone), 64'd2);
    check("b2b_busy_end", 64'(o_busy[0]), 64'd0);

    // Same-edge write and start to one writable word.
    a_write(8'd3, 8'hF0);
    a_addr = 8'd3; a_wdata = 8'h0F; a_wr_en = 1'b1; a_start = 1'b1; tick();
    a_wr_en = 1'b0; a_start = 1'b0;
    check("same_edge_wr", 64'(wr_lsb), 64'h0FA5FF);
    begin
      logic [7:0] cap; int busy_lo;
      a_capture(0, 1'b0, cap, busy_lo);
      check("same_edge_bits", 64'(cap), 64'hF0);
    end

    // Reset in the middle of an all-ones frame.
    a_addr = 8'd1; a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    check("pre_rst_serial", 64'(o_ser[0]), 64'h1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_serial", 64'(o_ser[0]), 64'h0);
    check("async_rst_busy", 64'(o_busy[0]), 64'h0);
    check("async_rst_wr", 64'(wr_lsb), 64'h0);
    tick(); tick();
    rstn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (o_done[0]) ndone++; end
    check("rst_no_done", 64'(ndone), 64'd0);

    // 16-bit instance.
    b_addr = 8'd2; b_wdata = 16'hA5C3; b_wr_en = 1'b1; tick(); b_wr_en = 1'b0;
    check("w16_wr", 64'(wr_w16), 64'hA5C30000);
    b_start = 1'b1; tick(); b_start = 1'b0;
    cap16 = '0;
    for (int i = 0; i < 16; i++) begin cap16[i] = o_ser[2]; tick(); end
    check("w16_bits", 64'(cap16), 64'hA5C3);
    check("w16_done", 64'(o_done[2]), 64'h1);

    // Randomized traffic on all instances, checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) begin
        for (int i = 0; i < 14; i++) a_ro[i*32 +: 32] = $urandom;
        for (int i = 0; i < 3; i++) b_ro[i*32 +: 32] = $urandom;
      end
      a_addr  = 8'($urandom_range(0, 62));
      a_wdata = 8'($urandom);
      a_wr_en = ($urandom_range(0, 3) == 0);
      a_start = ($urandom_range(0, 2) == 0);
      b_addr  = 8'($urandom_range(0, 10));
      b_wdata = 16'($urandom);
      b_wr_en = ($urandom_range(0, 3) == 0);
      b_start = ($urandom_range(0, 2) == 0);
      rstn    = (c != 700);
      tick();
    end
    a_wr_en = 1'b0; a_start = 1'b0; b_wr_en = 1'b0; b_start = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
